writeback_stage: RTL

- Final pipeline stage of the RV64 core; the producer side of the decode-stage register-file/CSR write and forwarding interface.
- Latches MEM-stage results and selects and sign-extends register write data.
- Computes the CSR read-modify-write value, detects traps (ECALL, misaligned load) and drives the CSR file's trap strobe.
- Drains the pipeline after a trap and counts retired instructions.

---
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/writeback_stage_if.sv
// MEM -> WB handshake bundle plus the WB-side register/CSR write and trap outputs.
// The master drives MEM-stage results; the slave (writeback_stage) returns writeback state.
interface writeback_stage_if;
    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_NPC;
    logic [63:0] MEM_ALU_RESULT;
    logic [63:0] MEM_DATA;
    logic [63:0] MEM_CSRFD;
    logic [63:0] MEM_RFD;
    logic [1:0]  PRIV;
    logic [31:0] WB_IR;
    logic        WB_V;
    logic [63:0] WB_ALU_RESULT;
    logic [63:0] WB_MEM_RESULT;
    logic [63:0] WB_RFD;
    logic        WB_ST_REG;
    logic [63:0] WB_CSRFD;
    logic        WB_ST_CSR;
    logic        WB_CS;
    logic [63:0] WB_CAUSE;
    logic        TRAP_FLUSH;
    logic [63:0] INSTRET;

    modport master (
        output MEM_V, MEM_IR, MEM_NPC, MEM_ALU_RESULT,
        output MEM_DATA, MEM_CSRFD, MEM_RFD, PRIV,
        input  WB_IR, WB_V, WB_ALU_RESULT, WB_MEM_RESULT,
        input  WB_RFD, WB_ST_REG, WB_CSRFD, WB_ST_CSR,
        input  WB_CS, WB_CAUSE, TRAP_FLUSH, INSTRET
    );

    modport slave (
        input  MEM_V, MEM_IR, MEM_NPC, MEM_ALU_RESULT,
        input  MEM_DATA, MEM_CSRFD, MEM_RFD, PRIV,
        output WB_IR, WB_V, WB_ALU_RESULT, WB_MEM_RESULT,
        output WB_RFD, WB_ST_REG, WB_CSRFD, WB_ST_CSR,
        output WB_CS, WB_CAUSE, TRAP_FLUSH, INSTRET
    );
endinterface

// File: rtl/writeback_stage.sv
// RV64 writeback stage: latches MEM results, builds register/CSR write data,
// raises ECALL / misaligned-load traps, drains the pipeline and counts retires.
module writeback_stage #(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input logic             CLK,
    input logic             RESET,
    writeback_stage_if.slave bus
);
    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP32  = 7'b0111011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wb_v_q;
    logic [31:0] ir_q;
    logic [63:0] npc_q, alu_q, data_q, csrfd_q, old_q;
    logic [63:0] instret_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1;
    logic        is_load, is_jump, is_csr, wr_op;
    logic        misal, ecall, trap;
    logic [63:0] sh, ld_ext, rfd, src, csr_wd, cause;

    assign opcode = ir_q[6:0];
    assign f3     = ir_q[14:12];
    assign rd     = ir_q[11:7];
    assign rs1    = ir_q[19:15];

    assign is_load = opcode == OP_LOAD;
    assign is_jump = (opcode == OP_JAL) | (opcode == OP_JALR);
    assign is_csr  = (opcode == OP_SYS) & (f3 != 3'b000);
    assign wr_op   = is_csr | (opcode inside {OP_OP, OP_IMM, OP_OP32,
                     OP_IMM32, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});

    // Bring the addressed lane down to bit 0, then extend by access size.
    assign sh = data_q >> {alu_q[2:0], 3'b000};

    always_comb begin
        ld_ext = sh;
        unique case (f3)
            3'b000:  ld_ext = {{56{sh[7]}}, sh[7:0]};
            3'b001:  ld_ext = {{48{sh[15]}}, sh[15:0]};
            3'b010:  ld_ext = {{32{sh[31]}}, sh[31:0]};
            3'b100:  ld_ext = {56'd0, sh[7:0]};
            3'b101:  ld_ext = {48'd0, sh[15:0]};
            3'b110:  ld_ext = {32'd0, sh[31:0]};
            default: ld_ext = sh;
        endcase
    end

    always_comb begin
        rfd = alu_q;
        unique case (1'b1)
            is_load: rfd = ld_ext;
            is_jump: rfd = npc_q;
            is_csr:  rfd = old_q;
            default: rfd = alu_q;
        endcase
    end

    assign src = f3[2] ? {59'd0, rs1} : csrfd_q;

    always_comb begin
        csr_wd = old_q;
        unique case (f3[1:0])
            2'b01:   csr_wd = src;
            2'b10:   csr_wd = old_q | src;
            2'b11:   csr_wd = old_q & ~src;
            default: csr_wd = old_q;
        endcase
    end

    always_comb begin
        misal = 1'b0;
        unique case (f3[1:0])
            2'b00: misal = 1'b0;
            2'b01: misal = alu_q[0];
            2'b10: misal = |alu_q[1:0];
            2'b11: misal = |alu_q[2:0];
        endcase
        misal = misal & is_load;
    end

    assign ecall = ir_q == 32'h0000_0073;
    assign trap  = wb_v_q & (misal | ecall);
    assign cause = misal ? 64'd4 : 64'd8 + {62'd0, bus.PRIV};

    assign bus.WB_IR         = ir_q;
    assign bus.WB_V          = wb_v_q;
    assign bus.WB_ALU_RESULT = alu_q;
    assign bus.WB_MEM_RESULT = ld_ext;
    assign bus.WB_RFD        = rfd;
    assign bus.WB_ST_REG     = wb_v_q & (rd != 5'd0) & wr_op & ~trap;
    assign bus.WB_CSRFD      = csr_wd;
    // Set/clear forms with a zero source never write the CSR.
    assign bus.WB_ST_CSR     = wb_v_q & is_csr & ~trap
                             & ~(f3[1] & (rs1 == 5'd0));
    assign bus.WB_CS         = trap;
    assign bus.WB_CAUSE      = trap ? cause : 64'd0;
    assign bus.TRAP_FLUSH    = trap | (state_q == DRAIN);
    assign bus.INSTRET       = instret_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            wb_v_q    <= 1'b0;
            ir_q      <= 32'd0;
            npc_q     <= 64'd0;
            alu_q     <= 64'd0;
            data_q    <= 64'd0;
            csrfd_q   <= 64'd0;
            old_q     <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            ir_q    <= bus.MEM_IR;
            npc_q   <= bus.MEM_NPC;
            alu_q   <= bus.MEM_ALU_RESULT;
            data_q  <= bus.MEM_DATA;
            csrfd_q <= bus.MEM_CSRFD;
            old_q   <= bus.MEM_RFD;
            wb_v_q  <= (state_q == RUN) & ~trap & bus.MEM_V;
            if (wb_v_q & ~trap)
                instret_q <= instret_q + 64'd1;
            unique case (state_q)
                RUN: begin
                    if (trap) begin
                        state_q <= DRAIN;
                        cnt_q   <= FC;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= RUN;
                end
            endcase
        end
    end
endmodule
